plic_claim_arbiter: RTL and testbench

//  Arbitration and claim/complete controller for the PLIC; single hart target.
//  - Consumes pending bits and per-source priority registers from the pending/priority register block.
//  - Selects the highest-priority enabled source above the threshold and drives irq_out to the core.
//  - Runs the claim/complete handshake.
//  - Returns active_interrupt + interrupt_claimed so the register block clears the claimed pending bit.

---
 rtl/plic_claim_arbiter_pkg.sv | 20 ++
 rtl/plic_claim_arbiter_if.sv | 30 +++
 rtl/plic_claim_arbiter_priority_tree.sv | 67 ++++++
 rtl/plic_claim_arbiter.sv | 129 ++++++++++++
 tb/tb_plic_claim_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_claim_arbiter_pkg.sv
// Shared types and helpers for the PLIC claim arbiter: FSM state encoding,
// ID width and the ID to one-hot conversion used when a claim is granted.
package plic_pkg;

    typedef enum logic [1:0] {IDLE, NOTIFY, SERVICE} plic_arb_state_t;

    localparam int PLIC_ID_W    = 32;
    localparam int PLIC_MAX_SRC = 1024;

    // ID 0 means "no interrupt" and maps to an all-zero vector.
    function automatic logic [PLIC_MAX_SRC-1:0] id_to_onehot(input logic [PLIC_ID_W-1:0] id);
        logic [PLIC_MAX_SRC-1:0] oh;
        oh = '0;
        for (int i = 0; i < PLIC_MAX_SRC; i++) begin
            oh[i] = (id == PLIC_ID_W'(i + 1));
        end
        return oh;
    endfunction

endpackage

// File: rtl/plic_claim_arbiter_if.sv
// Bundle between the pending/priority register block plus core claim/complete
// port (master) and the claim arbiter (slave).
interface plic_claim_arbiter_if #(
    parameter int N_INTERRUPTS = 32,
    parameter int PRIO_W       = 3
);
    logic [N_INTERRUPTS-1:0]                        pending_interrupts;
    logic [N_INTERRUPTS-1:0][plic_pkg::PLIC_ID_W-1:0] interrupt_priority_regs;
    logic [N_INTERRUPTS-1:0]                        enable_mask;
    logic [PRIO_W-1:0]                              threshold;
    logic                                           claim_req;
    logic                                           complete_req;
    logic [plic_pkg::PLIC_ID_W-1:0]                 complete_id;
    logic [plic_pkg::PLIC_ID_W-1:0]                 claim_id;
    logic [N_INTERRUPTS-1:0]                        active_interrupt;
    logic                                           interrupt_claimed;
    logic                                           irq_out;

    modport master (
        output pending_interrupts, interrupt_priority_regs, enable_mask, threshold,
        output claim_req, complete_req, complete_id,
        input  claim_id, active_interrupt, interrupt_claimed, irq_out
    );

    modport slave (
        input  pending_interrupts, interrupt_priority_regs, enable_mask, threshold,
        input  claim_req, complete_req, complete_id,
        output claim_id, active_interrupt, interrupt_claimed, irq_out
    );
endinterface

// File: rtl/plic_claim_arbiter_priority_tree.sv
// Combinational tournament max-find over eligible sources; on equal priority
// the left (lower-index) subtree always wins.
module plic_priority_tree #(
    parameter int N      = 32,
    parameter int PRIO_W = 3,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]             eligible,
    input  logic [N-1:0][PRIO_W-1:0] prio,
    output logic                     valid,
    output logic [IDX_W-1:0]         index,
    output logic [PRIO_W-1:0]        max_prio
);
    localparam int LEVELS = $clog2(N);
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [LEAVES-1:0]             leaf_valid;
    logic [LEAVES-1:0][IDX_W-1:0]  leaf_idx;
    logic [LEAVES-1:0][PRIO_W-1:0] leaf_prio;

    logic              node_valid [NODES];
    logic [IDX_W-1:0]  node_idx   [NODES];
    logic [PRIO_W-1:0] node_prio  [NODES];

    // Pad the source list up to a power of two with never-valid leaves.
    for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
        if (g < N) begin : g_real
            assign leaf_valid[g] = eligible[g];
            assign leaf_idx[g]   = IDX_W'(g);
            assign leaf_prio[g]  = prio[g];
        end else begin : g_pad
            assign leaf_valid[g] = 1'b0;
            assign leaf_idx[g]   = '0;
            assign leaf_prio[g]  = '0;
        end
    end

    // Heap layout: node n has children 2n+1 (lower indices) and 2n+2.
    always_comb begin
        node_valid = '{default: 1'b0};
        node_idx   = '{default: '0};
        node_prio  = '{default: '0};
        for (int i = 0; i < LEAVES; i++) begin
            node_valid[LEAVES-1+i] = leaf_valid[i];
            node_idx[LEAVES-1+i]   = leaf_idx[i];
            node_prio[LEAVES-1+i]  = leaf_prio[i];
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (node_valid[2*n+2] &&
                (!node_valid[2*n+1] || (node_prio[2*n+2] > node_prio[2*n+1]))) begin
                node_valid[n] = 1'b1;
                node_idx[n]   = node_idx[2*n+2];
                node_prio[n]  = node_prio[2*n+2];
            end else begin
                node_valid[n] = node_valid[2*n+1];
                node_idx[n]   = node_idx[2*n+1];
                node_prio[n]  = node_prio[2*n+1];
            end
        end
    end

    assign valid    = node_valid[0];
    assign index    = node_idx[0];
    assign max_prio = node_prio[0];

endmodule

// File: rtl/plic_claim_arbiter.sv
// PLIC arbitration and claim/complete controller for a single hart: registers
// the winning candidate, raises irq_out and tracks the one outstanding claim.
module plic_claim_arbiter
    import plic_pkg::*;
#(
    parameter int N_interrupts = 32,
    parameter int PRIO_W       = 3
) (
    input logic                 clk,
    input logic                 n_rst,
    plic_claim_arbiter_if.slave bus
);
    localparam int IDX_W = (N_interrupts > 1) ? $clog2(N_interrupts) : 1;

    plic_arb_state_t state_q, state_d;

    logic                    cand_valid_q;
    logic [PLIC_ID_W-1:0]    cand_id_q;
    logic [PRIO_W-1:0]       cand_prio_q;
    logic [PLIC_ID_W-1:0]    claim_id_q, claim_id_d;
    logic [PLIC_ID_W-1:0]    svc_id_q, svc_id_d;
    logic [N_interrupts-1:0] active_q, active_d;
    logic                    claimed_q, claimed_d;

    logic [N_interrupts-1:0][PRIO_W-1:0] prio;
    logic [N_interrupts-1:0]             eligible;
    logic                                tree_valid;
    logic [IDX_W-1:0]                    tree_idx;
    logic [PRIO_W-1:0]                   tree_prio;
    logic                                complete_hit;
    logic                                unused_bits;

    // Only the low PRIO_W bits of each priority register carry meaning.
    always_comb begin
        prio        = '0;
        eligible    = '0;
        unused_bits = ^cand_prio_q;
        for (int i = 0; i < N_interrupts; i++) begin
            prio[i]     = bus.interrupt_priority_regs[i][PRIO_W-1:0];
            eligible[i] = bus.pending_interrupts[i] & bus.enable_mask[i] & ~active_q[i] &
                          (prio[i] > bus.threshold);
            unused_bits = unused_bits ^ (^bus.interrupt_priority_regs[i][PLIC_ID_W-1:PRIO_W]);
        end
    end

    plic_priority_tree #(
        .N      (N_interrupts),
        .PRIO_W (PRIO_W),
        .IDX_W  (IDX_W)
    ) u_tree (
        .eligible (eligible),
        .prio     (prio),
        .valid    (tree_valid),
        .index    (tree_idx),
        .max_prio (tree_prio)
    );

    // Completion is matched against the in-service ID rather than claim_id,
    // because a stray claim during SERVICE overwrites claim_id with 0.
    assign complete_hit = (state_q == SERVICE) && bus.complete_req &&
                          (bus.complete_id == svc_id_q) && (svc_id_q != '0) &&
                          (svc_id_q <= PLIC_ID_W'(N_interrupts));

    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        svc_id_d   = svc_id_q;
        active_d   = active_q;
        claimed_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.claim_req) claim_id_d = '0;
                if (cand_valid_q)  state_d = NOTIFY;
            end
            NOTIFY: begin
                if (bus.claim_req && cand_valid_q) begin
                    state_d    = SERVICE;
                    claim_id_d = cand_id_q;
                    svc_id_d   = cand_id_q;
                    active_d   = N_interrupts'(id_to_onehot(cand_id_q));
                    claimed_d  = 1'b1;
                end else if (bus.claim_req) begin
                    state_d    = IDLE;
                    claim_id_d = '0;
                end else if (!cand_valid_q) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (complete_hit) begin
                    state_d  = IDLE;
                    active_d = '0;
                    svc_id_d = '0;
                end
                if (bus.claim_req) claim_id_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Candidate is re-registered every cycle; a claim always uses this copy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cand_valid_q <= 1'b0;
            cand_id_q    <= '0;
            cand_prio_q  <= '0;
            claim_id_q   <= '0;
            svc_id_q     <= '0;
            active_q     <= '0;
            claimed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_valid_q <= tree_valid;
            cand_id_q    <= tree_valid ? (PLIC_ID_W'(tree_idx) + PLIC_ID_W'(1)) : '0;
            cand_prio_q  <= tree_valid ? tree_prio : '0;
            claim_id_q   <= claim_id_d;
            svc_id_q     <= svc_id_d;
            active_q     <= active_d;
            claimed_q    <= claimed_d;
        end
    end

    assign bus.irq_out           = (state_q == NOTIFY);
    assign bus.claim_id          = claim_id_q;
    assign bus.active_interrupt  = active_q;
    assign bus.interrupt_claimed = claimed_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed bench for plic_claim_arbiter; the bench plays the register block,
// clearing a pending bit by hand once its claim has been taken.
module tb_plic_claim_arbiter;
    localparam int N  = 32;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic n_rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    plic_claim_arbiter_if #(.N_INTERRUPTS(N), .PRIO_W(PW)) bus ();

    plic_claim_arbiter #(.N_interrupts(N), .PRIO_W(PW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        n_rst                       = 1'b0;
        bus.pending_interrupts      = '0;
        bus.interrupt_priority_regs = '0;
        bus.enable_mask             = '1;
        bus.threshold               = '0;
        bus.claim_req               = 1'b0;
        bus.complete_req            = 1'b0;
        bus.complete_id             = '0;
        tick(2);
        n_rst = 1'b1;
        tick(1);
    endtask

    task automatic do_claim();
        bus.claim_req = 1'b1;
        tick(1);
        bus.claim_req = 1'b0;
    endtask

    task automatic do_complete(input logic [31:0] id);
        bus.complete_req = 1'b1;
        bus.complete_id  = id;
        tick(1);
        bus.complete_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.claim_id !== 32'd0) begin
            $display("[TB] FAIL reset_claim_id: got %0d expected 0", bus.claim_id); tests_failed++; end
        tests_run++;
        if (bus.active_interrupt !== 32'h0) begin
            $display("[TB] FAIL reset_active: got %h expected 0", bus.active_interrupt); tests_failed++; end
        tests_run++;
        if (bus.interrupt_claimed !== 1'b0 || bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL reset_pulse_irq: got %b%b expected 00", bus.interrupt_claimed, bus.irq_out); tests_failed++; end
    endtask

    task automatic test_basic_claim();
        do_reset();
        bus.interrupt_priority_regs[4] = 32'd2;
        bus.pending_interrupts[4]      = 1'b1;
        tick(1);
        tests_run++;
        if (bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL basic_irq_early: got %b expected 0", bus.irq_out); tests_failed++; end
        tick(1);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL basic_irq: got %b expected 1", bus.irq_out); tests_failed++; end
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd5) begin
            $display("[TB] FAIL basic_claim_id: got %0d expected 5", bus.claim_id); tests_failed++; end
        tests_run++;
        if (bus.active_interrupt !== 32'h10 || bus.interrupt_claimed !== 1'b1) begin
            $display("[TB] FAIL basic_active_pulse: got %h/%b expected 00000010/1", bus.active_interrupt, bus.interrupt_claimed); tests_failed++; end
        tests_run++;
        if (bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL basic_irq_in_service: got %b expected 0", bus.irq_out); tests_failed++; end
        bus.pending_interrupts[4] = 1'b0;
        tick(1);
        tests_run++;
        if (bus.interrupt_claimed !== 1'b0 || bus.active_interrupt !== 32'h10) begin
            $display("[TB] FAIL basic_pulse_width: got %b/%h expected 0/00000010", bus.interrupt_claimed, bus.active_interrupt); tests_failed++; end
        do_complete(32'd5);
        tests_run++;
        if (bus.active_interrupt !== 32'h0) begin
            $display("[TB] FAIL basic_complete: got %h expected 0", bus.active_interrupt); tests_failed++; end
    endtask

    task automatic test_tie_break();
        do_reset();
        bus.interrupt_priority_regs[3] = 32'd5;
        bus.interrupt_priority_regs[7] = 32'd5;
        bus.interrupt_priority_regs[1] = 32'd4;
        bus.pending_interrupts         = 32'h0000_008A;
        tick(2);
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd4 || bus.active_interrupt !== 32'h8) begin
            $display("[TB] FAIL tie_first: got %0d/%h expected 4/00000008", bus.claim_id, bus.active_interrupt); tests_failed++; end
        bus.pending_interrupts[3] = 1'b0;
        do_complete(32'd4);
        tick(1);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL tie_renotify: got %b expected 1", bus.irq_out); tests_failed++; end
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd8 || bus.active_interrupt !== 32'h80) begin
            $display("[TB] FAIL tie_second: got %0d/%h expected 8/00000080", bus.claim_id, bus.active_interrupt); tests_failed++; end
    endtask

    task automatic test_threshold();
        do_reset();
        bus.interrupt_priority_regs[6] = 32'd7;
        bus.pending_interrupts[6]      = 1'b1;
        tick(2);
        do_claim();
        bus.pending_interrupts[6] = 1'b0;
        do_complete(32'd7);
        tests_run++;
        if (bus.claim_id !== 32'd7) begin
            $display("[TB] FAIL thr_setup_claim: got %0d expected 7", bus.claim_id); tests_failed++; end
        bus.threshold                  = 3'd5;
        bus.interrupt_priority_regs[2] = 32'd5;
        bus.pending_interrupts[2]      = 1'b1;
        tick(3);
        tests_run++;
        if (bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL thr_masked_irq: got %b expected 0", bus.irq_out); tests_failed++; end
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd0 || bus.interrupt_claimed !== 1'b0) begin
            $display("[TB] FAIL thr_masked_claim: got %0d/%b expected 0/0", bus.claim_id, bus.interrupt_claimed); tests_failed++; end
        bus.threshold = 3'd4;
        tick(2);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL thr_lowered_irq: got %b expected 1", bus.irq_out); tests_failed++; end
    endtask

    task automatic test_mismatch_complete();
        do_reset();
        bus.interrupt_priority_regs[4] = 32'd2;
        bus.pending_interrupts[4]      = 1'b1;
        tick(2);
        do_claim();
        bus.pending_interrupts[4]      = 1'b0;
        bus.interrupt_priority_regs[9] = 32'd3;
        bus.pending_interrupts[9]      = 1'b1;
        do_complete(32'd6);
        tests_run++;
        if (bus.active_interrupt !== 32'h10 || bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL mm_wrong_id: got %h/%b expected 00000010/0", bus.active_interrupt, bus.irq_out); tests_failed++; end
        do_complete(32'h8000_0005);
        tests_run++;
        if (bus.active_interrupt !== 32'h10) begin
            $display("[TB] FAIL mm_upper_bits: got %h expected 00000010", bus.active_interrupt); tests_failed++; end
        do_complete(32'd0);
        tests_run++;
        if (bus.active_interrupt !== 32'h10) begin
            $display("[TB] FAIL mm_zero_id: got %h expected 00000010", bus.active_interrupt); tests_failed++; end
        do_complete(32'd5);
        tests_run++;
        if (bus.active_interrupt !== 32'h0) begin
            $display("[TB] FAIL mm_match: got %h expected 0", bus.active_interrupt); tests_failed++; end
        tick(1);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL mm_back_to_idle: got %b expected 1", bus.irq_out); tests_failed++; end
    endtask

    task automatic test_claim_complete_same_cycle();
        do_reset();
        bus.interrupt_priority_regs[4] = 32'd2;
        bus.pending_interrupts[4]      = 1'b1;
        tick(2);
        do_claim();
        bus.pending_interrupts[4]      = 1'b0;
        bus.interrupt_priority_regs[9] = 32'd3;
        bus.pending_interrupts[9]      = 1'b1;
        tick(1);
        bus.claim_req    = 1'b1;
        bus.complete_req = 1'b1;
        bus.complete_id  = 32'd5;
        tick(1);
        bus.claim_req    = 1'b0;
        bus.complete_req = 1'b0;
        tests_run++;
        if (bus.claim_id !== 32'd0 || bus.interrupt_claimed !== 1'b0) begin
            $display("[TB] FAIL same_claim: got %0d/%b expected 0/0", bus.claim_id, bus.interrupt_claimed); tests_failed++; end
        tests_run++;
        if (bus.active_interrupt !== 32'h0) begin
            $display("[TB] FAIL same_active: got %h expected 0", bus.active_interrupt); tests_failed++; end
        tick(1);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL same_idle_notify: got %b expected 1", bus.irq_out); tests_failed++; end
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd10) begin
            $display("[TB] FAIL same_next_claim: got %0d expected 10", bus.claim_id); tests_failed++; end
    endtask

    task automatic test_enable_mask();
        do_reset();
        bus.pending_interrupts[11] = 1'b1;
        tick(3);
        tests_run++;
        if (bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL en_prio_zero: got %b expected 0", bus.irq_out); tests_failed++; end
        bus.interrupt_priority_regs[5] = 32'd7;
        bus.pending_interrupts[5]      = 1'b1;
        bus.enable_mask[5]             = 1'b0;
        bus.interrupt_priority_regs[6] = 32'd1;
        bus.pending_interrupts[6]      = 1'b1;
        tick(2);
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd7 || bus.active_interrupt !== 32'h40) begin
            $display("[TB] FAIL en_masked: got %0d/%h expected 7/00000040", bus.claim_id, bus.active_interrupt); tests_failed++; end
    endtask

    task automatic test_reset_mid_service();
        do_reset();
        bus.interrupt_priority_regs[4] = 32'd2;
        bus.pending_interrupts[4]      = 1'b1;
        tick(2);
        do_claim();
        tests_run++;
        if (bus.active_interrupt !== 32'h10) begin
            $display("[TB] FAIL rst_setup: got %h expected 00000010", bus.active_interrupt); tests_failed++; end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        tests_run++;
        if (bus.claim_id !== 32'd0 || bus.active_interrupt !== 32'h0 ||
            bus.interrupt_claimed !== 1'b0 || bus.irq_out !== 1'b0) begin
            $display("[TB] FAIL rst_async: got %0d/%h/%b/%b expected 0/0/0/0", bus.claim_id, bus.active_interrupt, bus.interrupt_claimed, bus.irq_out); tests_failed++; end
        bus.pending_interrupts         = '0;
        bus.interrupt_priority_regs    = '0;
        bus.interrupt_priority_regs[0] = 32'd1;
        bus.pending_interrupts[0]      = 1'b1;
        tick(1);
        n_rst = 1'b1;
        tick(2);
        tests_run++;
        if (bus.irq_out !== 1'b1) begin
            $display("[TB] FAIL rst_release_irq: got %b expected 1", bus.irq_out); tests_failed++; end
        do_claim();
        tests_run++;
        if (bus.claim_id !== 32'd1 || bus.active_interrupt !== 32'h1) begin
            $display("[TB] FAIL rst_release_claim: got %0d/%h expected 1/00000001", bus.claim_id, bus.active_interrupt); tests_failed++; end
    endtask

    initial begin
        test_reset();
        test_basic_claim();
        test_tie_break();
        test_threshold();
        test_mismatch_complete();
        test_claim_complete_same_cycle();
        test_enable_mask();
        test_reset_mid_service();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
